decode_issue: RTL and testbench

DECODE_ISSUE -- requirements
Module: decode_issue

---
 rtl/alu_pkg.sv | 54 +++++
 rtl/decode_issue_regfile.sv | 47 ++++
 rtl/decode_issue.sv | 173 +++++++++++++++++
 tb/tb_decode_issue.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared constants for the decode/issue slice: fixed widths,
//           instruction field positions, ALU function codes and the
//           is_legal / writes_r0 decode helpers.
// Revision: 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_W    = 4;
  localparam int FUNC_W   = 4;
  localparam int NUM_REGS = 16;

  // Instruction word layout: [15:12] dst, [11:8] srcA, [7:4] srcB, [3:0] func
  localparam int DST_MSB  = 15;
  localparam int DST_LSB  = 12;
  localparam int SRCA_MSB = 11;
  localparam int SRCA_LSB = 8;
  localparam int SRCB_MSB = 7;
  localparam int SRCB_LSB = 4;
  localparam int FUNC_MSB = 3;
  localparam int FUNC_LSB = 0;

  localparam logic [FUNC_W-1:0] C_FN_ADD = 4'b1111;
  localparam logic [FUNC_W-1:0] C_FN_SUB = 4'b1110;
  localparam logic [FUNC_W-1:0] C_FN_AND = 4'b1101;
  localparam logic [FUNC_W-1:0] C_FN_OR  = 4'b1100;
  localparam logic [FUNC_W-1:0] C_FN_MUL = 4'b0001;
  localparam logic [FUNC_W-1:0] C_FN_DIV = 4'b0010;
  localparam logic [FUNC_W-1:0] C_FN_SHL = 4'b1010;
  localparam logic [FUNC_W-1:0] C_FN_SHR = 4'b1011;
  localparam logic [FUNC_W-1:0] C_FN_ROL = 4'b1000;
  localparam logic [FUNC_W-1:0] C_FN_ROR = 4'b1001;

  function automatic logic is_legal(input logic [FUNC_W-1:0] f);
    logic ok;
    case (f)
      C_FN_ADD, C_FN_SUB, C_FN_AND, C_FN_OR, C_FN_MUL,
      C_FN_DIV, C_FN_SHL, C_FN_SHR, C_FN_ROL, C_FN_ROR: ok = 1'b1;
      default:                                          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Multiply and divide return a second result (high product / remainder)
  // that the ALU writes back into register 0.
  function automatic logic writes_r0(input logic [FUNC_W-1:0] f);
    return (f == C_FN_MUL) || (f == C_FN_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_issue_regfile.sv
`default_nettype none
// ============================================================================
// Module  : regfile
// Purpose : 16 x 16-bit register file, two asynchronous read ports and two
//           write ports. The dedicated register-0 port wins over the general
//           port when both address register 0 in the same cycle.
// Ports   : clk, rst (sync, active-low)
//           i_rd_addr_a/b -> o_rd_data_a/b   asynchronous reads
//           i_wr_en, i_wr_addr, i_wr_data     general write port
//           i_r0_wr_en, i_r0_wr_data          register-0 write port
// Revision: 1.0  initial release
// ============================================================================
module regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  i_rd_addr_a,
  input  logic [REG_W-1:0]  i_rd_addr_b,
  output logic [DATA_W-1:0] o_rd_data_a,
  output logic [DATA_W-1:0] o_rd_data_b,
  input  logic              i_wr_en,
  input  logic [REG_W-1:0]  i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_r0_wr_en,
  input  logic [DATA_W-1:0] i_r0_wr_data
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!rst) begin
        r_regs[i] <= '0;
      end else if ((i == 0) && i_r0_wr_en) begin
        r_regs[i] <= i_r0_wr_data;
      end else if (i_wr_en && (i_wr_addr == REG_W'(i))) begin
        r_regs[i] <= i_wr_data;
      end
    end
  end

  assign o_rd_data_a = r_regs[i_rd_addr_a];
  assign o_rd_data_b = r_regs[i_rd_addr_b];

endmodule
`default_nettype wire

// File: rtl/decode_issue.sv
`default_nettype none
// ============================================================================
// Module  : decode_issue
// Purpose : Decodes 16-bit instruction words, checks a per-register busy
//           scoreboard for hazards, reads operands and presents them in a
//           single registered issue slot to the ALU. Writebacks from the ALU
//           update the register file and release busy bits.
// Ports   : clk, rst (sync, active-low)
//           instr_valid/instr/instr_ready           instruction handshake
//           iss_valid/iss_ready, iss_func, iss_in1,
//           iss_in2, iss_dst, iss_wr_r0             issue slot to ALU
//           wb_en/wb_dst/wb_out, wb_r0_en/wb_r0     writeback from ALU
//           illegal                                 undefined-code pulse
// Config  : DECODE_BYPASS_EN - when defined, writebacks arriving in the
//           acceptance cycle are forwarded to the operands and the busy bits
//           they release no longer stall that cycle.
// Revision: 1.0  initial release
// ============================================================================
module decode_issue
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr,
  output logic              instr_ready,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [FUNC_W-1:0] iss_func,
  output logic [DATA_W-1:0] iss_in1,
  output logic [DATA_W-1:0] iss_in2,
  output logic [REG_W-1:0]  iss_dst,
  output logic              iss_wr_r0,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_dst,
  input  logic [DATA_W-1:0] wb_out,
  input  logic              wb_r0_en,
  input  logic [DATA_W-1:0] wb_r0,
  output logic              illegal
);

  logic [REG_W-1:0]    w_dst;
  logic [REG_W-1:0]    w_srca;
  logic [REG_W-1:0]    w_srcb;
  logic [FUNC_W-1:0]   w_func;
  logic                w_legal;
  logic                w_wr_r0;
  logic                w_hazard;
  logic                w_slot_free;
  logic                w_accept;
  logic                w_issue;
  logic [NUM_REGS-1:0] w_busy_clr;
  logic [NUM_REGS-1:0] w_busy_set;
  logic [NUM_REGS-1:0] w_busy_view;
  logic [DATA_W-1:0]   w_rf_a;
  logic [DATA_W-1:0]   w_rf_b;
  logic [DATA_W-1:0]   w_op_a;
  logic [DATA_W-1:0]   w_op_b;

  logic [NUM_REGS-1:0] r_busy;
  logic                r_iss_valid;
  logic [FUNC_W-1:0]   r_iss_func;
  logic [DATA_W-1:0]   r_iss_in1;
  logic [DATA_W-1:0]   r_iss_in2;
  logic [REG_W-1:0]    r_iss_dst;
  logic                r_iss_wr_r0;
  logic                r_illegal;

  assign w_dst   = instr[DST_MSB:DST_LSB];
  assign w_srca  = instr[SRCA_MSB:SRCA_LSB];
  assign w_srcb  = instr[SRCB_MSB:SRCB_LSB];
  assign w_func  = instr[FUNC_MSB:FUNC_LSB];
  assign w_legal = is_legal(w_func);
  assign w_wr_r0 = writes_r0(w_func);

  regfile u_regfile (
    .clk          (clk),
    .rst          (rst),
    .i_rd_addr_a  (w_srca),
    .i_rd_addr_b  (w_srcb),
    .o_rd_data_a  (w_rf_a),
    .o_rd_data_b  (w_rf_b),
    .i_wr_en      (wb_en),
    .i_wr_addr    (wb_dst),
    .i_wr_data    (wb_out),
    .i_r0_wr_en   (wb_r0_en),
    .i_r0_wr_data (wb_r0)
  );

  always_comb begin
    w_busy_clr = '0;
    if (wb_en)    w_busy_clr[wb_dst] = 1'b1;
    if (wb_r0_en) w_busy_clr[0]      = 1'b1;
  end

  always_comb begin
    w_busy_set = '0;
    if (w_issue) begin
      w_busy_set[w_dst] = 1'b1;
      if (w_wr_r0) w_busy_set[0] = 1'b1;
    end
  end

`ifdef DECODE_BYPASS_EN
  // Bits released this cycle no longer block, and their data is forwarded.
  assign w_busy_view = r_busy & ~w_busy_clr;

  // Register 0 takes wb_r0 over wb_out, matching the register file priority.
  always_comb begin
    w_op_a = w_rf_a;
    if (wb_r0_en && (w_srca == '0))   w_op_a = wb_r0;
    else if (wb_en && (wb_dst == w_srca)) w_op_a = wb_out;
  end

  always_comb begin
    w_op_b = w_rf_b;
    if (wb_r0_en && (w_srcb == '0))   w_op_b = wb_r0;
    else if (wb_en && (wb_dst == w_srcb)) w_op_b = wb_out;
  end
`else
  // Registered busy bits only: a released register is usable one cycle after
  // its writeback, by which time the register file already holds the value.
  assign w_busy_view = r_busy;
  assign w_op_a      = w_rf_a;
  assign w_op_b      = w_rf_b;
`endif

  assign w_hazard = w_busy_view[w_srca] | w_busy_view[w_srcb] |
                    w_busy_view[w_dst]  | (w_wr_r0 & w_busy_view[0]);

  assign w_slot_free = !r_iss_valid || iss_ready;
  // Illegal codes never touch the scoreboard, so they need not wait on it.
  assign instr_ready = w_slot_free && (!w_legal || !w_hazard);
  assign w_accept    = instr_valid && instr_ready;
  assign w_issue     = w_accept && w_legal;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy      <= '0;
      r_iss_valid <= 1'b0;
      r_iss_func  <= '0;
      r_iss_in1   <= '0;
      r_iss_in2   <= '0;
      r_iss_dst   <= '0;
      r_iss_wr_r0 <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      // Set after clear so a simultaneous set and clear leaves the bit set.
      r_busy    <= (r_busy & ~w_busy_clr) | w_busy_set;
      r_illegal <= w_accept && !w_legal;
      if (w_issue) begin
        r_iss_valid <= 1'b1;
        r_iss_func  <= w_func;
        r_iss_in1   <= w_op_a;
        r_iss_in2   <= w_op_b;
        r_iss_dst   <= w_dst;
        r_iss_wr_r0 <= w_wr_r0;
      end else if (iss_ready) begin
        r_iss_valid <= 1'b0;
      end
    end
  end

  assign iss_valid = r_iss_valid;
  assign iss_func  = r_iss_func;
  assign iss_in1   = r_iss_in1;
  assign iss_in2   = r_iss_in2;
  assign iss_dst   = r_iss_dst;
  assign iss_wr_r0 = r_iss_wr_r0;
  assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue.sv
`default_nettype none
// ============================================================================
// Module  : tb_decode_issue
// Purpose : Self-checking bench for decode_issue. A table of single
//           instructions with preloaded operands checks decode and operand
//           read; hand-written sequences cover stalls, back-pressure,
//           register-0 write priority, scoreboard set/clear and reset.
// Revision: 1.0  initial release
// ============================================================================
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        iss_valid;
  logic        iss_ready;
  logic [3:0]  iss_func;
  logic [15:0] iss_in1;
  logic [15:0] iss_in2;
  logic [3:0]  iss_dst;
  logic        iss_wr_r0;
  logic        wb_en;
  logic [3:0]  wb_dst;
  logic [15:0] wb_out;
  logic        wb_r0_en;
  logic [15:0] wb_r0;
  logic        illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_issue dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .iss_valid   (iss_valid),
    .iss_ready   (iss_ready),
    .iss_func    (iss_func),
    .iss_in1     (iss_in1),
    .iss_in2     (iss_in2),
    .iss_dst     (iss_dst),
    .iss_wr_r0   (iss_wr_r0),
    .wb_en       (wb_en),
    .wb_dst      (wb_dst),
    .wb_out      (wb_out),
    .wb_r0_en    (wb_r0_en),
    .wb_r0       (wb_r0),
    .illegal     (illegal)
  );

  typedef struct {
    logic [15:0] instr;
    logic [15:0] a;      // value preloaded into srcA
    logic [15:0] b;      // value preloaded into srcB
    logic        legal;
    logic        wr0;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    instr_valid = 1'b0;
    instr       = '0;
    iss_ready   = 1'b1;
    wb_en       = 1'b0;
    wb_dst      = '0;
    wb_out      = '0;
    wb_r0_en    = 1'b0;
    wb_r0       = '0;
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic wb(input logic [3:0] d, input logic [15:0] v);
    wb_en  = 1'b1;
    wb_dst = d;
    wb_out = v;
    tick();
    wb_en  = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [3:0] sa, sb;

    vt[0]  = '{16'h312F, 16'h0005, 16'h0007, 1'b1, 1'b0}; // add r3=r1+r2
    vt[1]  = '{16'h456E, 16'h1234, 16'h0F0F, 1'b1, 1'b0}; // sub
    vt[2]  = '{16'h789D, 16'hBEEF, 16'h00FF, 1'b1, 1'b0}; // and
    vt[3]  = '{16'hABCC, 16'h8001, 16'h7FFE, 1'b1, 1'b0}; // or
    vt[4]  = '{16'h3121, 16'h0011, 16'h0022, 1'b1, 1'b1}; // mul
    vt[5]  = '{16'h5672, 16'h0100, 16'h0003, 1'b1, 1'b1}; // div
    vt[6]  = '{16'h123A, 16'hFFFF, 16'h0004, 1'b1, 1'b0}; // shl
    vt[7]  = '{16'h234B, 16'hA5A5, 16'h0001, 1'b1, 1'b0}; // shr
    vt[8]  = '{16'h3458, 16'h0F00, 16'h0008, 1'b1, 1'b0}; // rol
    vt[9]  = '{16'h4569, 16'h00F0, 16'h000C, 1'b1, 1'b0}; // ror
    vt[10] = '{16'h1235, 16'h1111, 16'h2222, 1'b0, 1'b0}; // 0101 illegal
    vt[11] = '{16'h1230, 16'h3333, 16'h4444, 1'b0, 1'b0}; // 0000 illegal
    vt[12] = '{16'h1237, 16'h5555, 16'h6666, 1'b0, 1'b0}; // 0111 illegal
    vt[13] = '{16'h10A4, 16'h7777, 16'h8888, 1'b0, 1'b0}; // 0100 illegal

    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // Reset state
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_iss_func",  iss_func,  0);
    chk("rst_iss_in1",   iss_in1,   0);
    chk("rst_iss_in2",   iss_in2,   0);
    chk("rst_iss_dst",   iss_dst,   0);
    chk("rst_iss_wr_r0", iss_wr_r0, 0);
    chk("rst_illegal",   illegal,   0);
    #1;
    chk("rst_instr_ready", instr_ready, 1);

    // Table: decode, operand read, one-cycle illegal pulse
    for (int i = 0; i < NV; i++) begin
      v  = vt[i];
      sa = v.instr[11:8];
      sb = v.instr[7:4];
      do_reset();
      wb(sa, v.a);
      wb(sb, v.b);
      instr_valid = 1'b1;
      instr       = v.instr;
      #1;
      chk("tbl_ready", instr_ready, 1);
      tick();
      instr_valid = 1'b0;
      chk("tbl_iss_valid", iss_valid, v.legal);
      chk("tbl_illegal",   illegal,   !v.legal);
      chk("tbl_func",      iss_func,  v.legal ? v.instr[3:0] : 4'h0);
      chk("tbl_in1",       iss_in1,   v.legal ? v.a : 16'h0);
      chk("tbl_in2",       iss_in2,   v.legal ? v.b : 16'h0);
      chk("tbl_dst",       iss_dst,   v.legal ? v.instr[15:12] : 4'h0);
      chk("tbl_wr_r0",     iss_wr_r0, v.wr0);
      tick();
      chk("tbl_illegal_end", illegal, 0);
      chk("tbl_valid_drop",  iss_valid, 0);
    end

    // mul then dependent mul: stall until writeback releases r3 and r0
    do_reset();
    instr_valid = 1'b1;
    instr       = 16'h3121;
    #1;
    chk("mul_ready", instr_ready, 1);
    tick();
    instr = 16'h4301;
    #1;
    chk("dep_stall0", instr_ready, 0);
    tick();
    chk("dep_slot_empty", iss_valid, 0);
    chk("dep_stall1", instr_ready, 0);
    wb_en    = 1'b1;
    wb_dst   = 4'd3;
    wb_out   = 16'h0042;
    wb_r0_en = 1'b1;
    wb_r0    = 16'h0009;
    #1;
`ifdef DECODE_BYPASS_EN
    chk("dep_ready_wb", instr_ready, 1);
    tick();
    wb_en       = 1'b0;
    wb_r0_en    = 1'b0;
    instr_valid = 1'b0;
`else
    chk("dep_ready_wb", instr_ready, 0);
    tick();
    wb_en    = 1'b0;
    wb_r0_en = 1'b0;
    #1;
    chk("dep_ready_after", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
`endif
    chk("dep_iss_valid", iss_valid, 1);
    chk("dep_in1",       iss_in1,   16'h0042);
    chk("dep_in2",       iss_in2,   16'h0009);
    chk("dep_dst",       iss_dst,   4'd4);
    chk("dep_wr_r0",     iss_wr_r0, 1);

    // Illegal code leaves the scoreboard alone
    do_reset();
    instr_valid = 1'b1;
    instr       = 16'h1235;
    #1;
    chk("ill_ready", instr_ready, 1);
    tick();
    instr = 16'h2111;
    #1;
    chk("ill_pulse",     illegal,     1);
    chk("ill_no_issue",  iss_valid,   0);
    chk("ill_busy_free", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
    chk("ill_pulse_end", illegal,   0);
    chk("ill_next_dst",  iss_dst,   4'd2);

    // Back-pressure: slot holds for 4 cycles, nothing else issues
    do_reset();
    wb(4'd1, 16'd5);
    wb(4'd2, 16'd7);
    instr_valid = 1'b1;
    instr       = 16'h312F;
    tick();
    iss_ready = 1'b0;
    instr     = 16'h567F;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_ready", instr_ready, 0);
      chk("bp_valid", iss_valid,   1);
      chk("bp_func",  iss_func,    4'hF);
      chk("bp_in1",   iss_in1,     16'd5);
      chk("bp_in2",   iss_in2,     16'd7);
      chk("bp_dst",   iss_dst,     4'd3);
      tick();
    end
    iss_ready = 1'b1;
    #1;
    chk("bp_release_ready", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
    chk("bp_second_valid", iss_valid, 1);
    chk("bp_second_dst",   iss_dst,   4'd5);
    tick();
    chk("bp_drain", iss_valid, 0);

    // Both writeback ports target register 0: wb_r0 wins
    do_reset();
    wb_r0_en = 1'b1;
    wb_r0    = 16'h5555;
    wb(4'd0, 16'hAAAA);
    wb_r0_en    = 1'b0;
    instr_valid = 1'b1;
    instr       = 16'h100F;
    #1;
    chk("r0_ready", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
    chk("r0_in1", iss_in1, 16'h5555);
    chk("r0_in2", iss_in2, 16'h5555);

    // Scoreboard set and clear of the same bit in one cycle: set wins
    do_reset();
    instr_valid = 1'b1;
    instr       = 16'h512F;
    wb_en       = 1'b1;
    wb_dst      = 4'd5;
    wb_out      = 16'h0777;
    #1;
    chk("sc_ready", instr_ready, 1);
    tick();
    wb_en = 1'b0;
    instr = 16'h655F;
    #1;
    chk("sc_busy_kept", instr_ready, 0);
    instr_valid = 1'b0;

    // Reset mid-stall with a pending issue and a writeback in the reset cycle
    do_reset();
    instr_valid = 1'b1;
    instr       = 16'h312F;
    tick();
    iss_ready = 1'b0;
    instr     = 16'h435F;
    #1;
    chk("rs_stall", instr_ready, 0);
    tick();
    rst    = 1'b0;
    wb_en  = 1'b1;
    wb_dst = 4'd5;
    wb_out = 16'h1111;
    tick();
    rst       = 1'b1;
    wb_en     = 1'b0;
    iss_ready = 1'b1;
    chk("rs_iss_valid", iss_valid, 0);
    #1;
    chk("rs_ready", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
    chk("rs_accept_valid", iss_valid, 1);
    chk("rs_accept_dst",   iss_dst,   4'd4);
    chk("rs_wb_ignored",   iss_in2,   16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
